// File: rtl/pll_div_pkg.sv
// Shared types and constants for the PLL feedback divider.
package pll_div_pkg;

    localparam int W_DEF    = 8;
    localparam int NDEF_DEF = 16;
    localparam int NMIN     = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } div_state_t;

endpackage

// File: rtl/pll_div_ratio_reg.sv
// Shadow ratio register with load/busy/ack handshake and sticky error flag.
module pll_div_ratio_reg
    import pll_div_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int NDEF = NDEF_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] n,
    input  logic         apply,
    output logic [W-1:0] nsh,
    output logic         busy,
    output logic         ack,
    output logic         err
);

    logic [W-1:0] nsh_q, nsh_d;
    logic         pend_q, pend_d;
    logic         ack_q, ack_d;
    logic         err_q, err_d;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch can be inferred.
        nsh_d  = nsh_q;
        pend_d = pend_q;
        ack_d  = 1'b0;
        err_d  = err_q;

        if (apply && pend_q) begin
            pend_d = 1'b0;
            ack_d  = 1'b1;
        end

        // A pending ratio locks out new requests, including on the edge that applies it.
        if (load && !pend_q) begin
            if (n >= W'(NMIN)) begin
                nsh_d  = n;
                pend_d = 1'b1;
                err_d  = 1'b0;
            end else begin
                err_d  = 1'b1;
            end
        end
    end

    // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nsh_q  <= W'(NDEF);
            pend_q <= 1'b0;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            nsh_q  <= nsh_d;
            pend_q <= pend_d;
            ack_q  <= ack_d;
            err_q  <= err_d;
        end
    end

    assign nsh  = nsh_q;
    assign busy = pend_q;
    assign ack  = ack_q;
    assign err  = err_q;

endmodule

// File: rtl/pll_fb_divider.sv
// Programmable integer feedback divider: registered near-50% FB output plus period-start pulse.
module pll_fb_divider
    import pll_div_pkg::*;
#(
    parameter int W    = W_DEF,
    parameter int NDEF = NDEF_DEF
) (
    input  logic         CLK,
    input  logic         Resetn,
    input  logic         Enable,
    input  logic [W-1:0] N,
    input  logic         Load,
    output logic         Busy,
    output logic         Ack,
    output logic         Err,
    output logic         FB,
    output logic         FBP
);

    div_state_t   state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] nact_q, nact_d;
    logic         fb_q, fb_d;
    logic         fbp_q, fbp_d;

    logic         apply;
    logic         busy;
    logic [W-1:0] nsh;
    logic [W:0]   half;
    logic [W:0]   cnt_inc;
    logic         wrap;

    pll_div_ratio_reg #(
        .W    (W),
        .NDEF (NDEF)
    ) u_ratio_reg (
        .clk   (CLK),
        .rst_n (Resetn),
        .load  (Load),
        .n     (N),
        .apply (apply),
        .nsh   (nsh),
        .busy  (busy),
        .ack   (Ack),
        .err   (Err)
    );

    // One extra bit keeps (Nact+1) from overflowing at the top of the ratio range.
    assign half    = ({1'b0, nact_q} + (W+1)'(1)) >> 1;
    assign cnt_inc = {1'b0, cnt_q} + (W+1)'(1);
    assign wrap    = (cnt_q == nact_q - W'(1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nact_d  = nact_q;
        fb_d    = fb_q;
        fbp_d   = 1'b0;
        apply   = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                fb_d  = 1'b0;
                apply = busy;
                if (Enable) begin
                    state_d = RUN;
                    fb_d    = 1'b1;
                    fbp_d   = 1'b1;
                end
            end
            RUN: begin
                if (!Enable) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    fb_d    = 1'b0;
                end else if (wrap) begin
                    cnt_d = '0;
                    fb_d  = 1'b1;
                    fbp_d = 1'b1;
                    apply = busy;
                end else begin
                    cnt_d = cnt_inc[W-1:0];
                    fb_d  = (cnt_inc < half);
                end
            end
            default: state_d = IDLE;
        endcase

        if (apply) begin
            nact_d = nsh;
        end
    end

    always_ff @(posedge CLK or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            nact_q  <= W'(NDEF);
            fb_q    <= 1'b0;
            fbp_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nact_q  <= nact_d;
            fb_q    <= fb_d;
            fbp_q   <= fbp_d;
        end
    end

    assign Busy = busy;
    assign FB   = fb_q;
    assign FBP  = fbp_q;

endmodule
